// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-stage data-memory controller.
// Takes the M-stage load/store, runs it on a variable-latency req/ack bus,
// returns the aligned read word and stalls the pipeline until the access
// is done. A bus that never acks is aborted after TIMEOUT busy cycles.
//
// Optional feature: define DMEM_WBUF_EN for a one-entry posted write buffer.
// Stores are then accepted without stalling and drained in the background.
//
// Ports:
//   clk, reset       clock (rising edge), async active-low reset
//   req_valid        M stage holds a load or store
//   req_we           1 = store, 0 = load
//   req_addr         byte address
//   req_wdata        lane-positioned store data
//   req_amp          byte-lane enables for stores
//   rdata            aligned read word, valid in the DONE cycle
//   stall            combinational pipeline freeze
//   err              one-cycle pulse on timeout abort
//   bus_req/we/addr/wdata/be   registered bus request
//   bus_ack          one-cycle completion strobe
//   bus_rdata        read data, valid with bus_ack
module dmem_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [3:0]      req_amp,
   output logic [XLEN-1:0] rdata,
   output logic            stall,
   output logic            err,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   output logic [3:0]      bus_be,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [XLEN-1:0] bus_addr_q, bus_addr_d;
   logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]      bus_be_q, bus_be_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   // Word alignment drops the byte offset; the datapath does lane extraction.
   logic            unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];

   logic            needs_bus;
   assign needs_bus = ~req_we | (req_amp != 4'b0000);

`ifdef DMEM_WBUF_EN
   // Set while the in-flight access is a posted store nobody is waiting on.
   logic            wbuf_q, wbuf_d;
   logic            post_now;
   assign post_now = (state_q == S_IDLE) & req_we & (req_amp != 4'b0000);
   // A posted store releases the pipeline at once; anything arriving behind a
   // draining store is held through that drain's DONE and handled from IDLE.
   assign stall = req_valid & ~post_now & ((state_q != S_DONE) | wbuf_q);
`else
   assign stall = req_valid & (state_q != S_DONE);
`endif

   // Next-state and next-register logic
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;
`ifdef DMEM_WBUF_EN
      wbuf_d      = wbuf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (needs_bus) begin
                  bus_req_d   = 1'b1;
                  bus_we_d    = req_we;
                  bus_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                  bus_wdata_d = req_wdata;
                  bus_be_d    = req_we ? req_amp : 4'b1111;
                  cnt_d       = '0;
                  state_d     = S_BUSY;
`ifdef DMEM_WBUF_EN
                  wbuf_d      = req_we;
`endif
               end else begin
                  // Store with no lanes enabled: nothing to put on the bus.
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            // Ack takes priority over a simultaneous timeout.
            if (bus_ack) begin
               if (!bus_we_q) begin
                  rdata_d = bus_rdata;
               end
               bus_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               bus_req_d = 1'b0;
               rdata_d   = '0;
               err_d     = 1'b1;
               cnt_d     = '0;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef DMEM_WBUF_EN
            wbuf_d  = 1'b0;
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
`ifdef DMEM_WBUF_EN
         wbuf_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
`ifdef DMEM_WBUF_EN
         wbuf_q      <= wbuf_d;
`endif
      end
   end

   assign rdata     = rdata_q;
   assign err       = err_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_be    = bus_be_q;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Memory-stage data-memory controller, directly downstream of the pipeline datapath's M stage.
- Accepts the M-stage access (address, write data, write enable, 4-bit access pattern) and runs it on a variable-latency req/ack data bus.
- Returns the full aligned read word to the datapath; lb/lh extraction remains in the datapath.
- Drives a stall that freezes the pipeline until the access completes, with a timeout abort.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 16, max cycles in BUSY waiting for bus_ack before abort; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  M stage holds a load or store (memtoregM | memwriteM).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  XLEN  byte address (aluoutM).
- req_wdata  in  XLEN  store data, already lane-positioned.
- req_amp  in  4  byte-lane enables for stores (ampM); ignored for loads.
- rdata  out  XLEN  read word (readdataM), valid in the DONE cycle.
- stall  out  1  combinational; freezes all pipeline registers.
- err  out  1  one-cycle pulse on timeout abort.
- bus_req  out  1  registered bus request.
- bus_we  out  1  registered.
- bus_addr  out  XLEN  registered, {req_addr[XLEN-1:2],2'b00}.
- bus_wdata  out  XLEN  registered.
- bus_be  out  4  registered; loads 4'b1111, stores req_amp.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  XLEN  valid with bus_ack.

Behaviour:
- Reset (async, reset=0): state IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, rdata=0, err=0, timeout counter=0.
- Reset mid-transaction drops bus_req immediately. Any bus_ack arriving after reset release while in IDLE is ignored.
- Pipeline contract: req_* stay stable while stall=1.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req_valid=0 -> stay.
  - req_valid=1 and (req_we=0 or req_amp!=0) -> latch bus_* and set bus_req=1; go BUSY.
  - req_we=1 and req_amp=0 -> no bus access; go DONE.
- BUSY: bus_req held 1; counter increments each cycle.
  - bus_ack=1 -> rdata<=bus_rdata (loads; stores leave rdata unchanged); bus_req<=0; counter<=0; go DONE.
  - No ack and counter==TIMEOUT-1 -> bus_req<=0; rdata<=0; err pulses 1 cycle; go DONE.
  - bus_ack and timeout in the same cycle: ack wins, no err.
- DONE: one cycle, then IDLE. The pipeline advances at this edge.
- stall = req_valid & (state != DONE), i.e. stall is also 1 in the IDLE cycle a request first appears.
- Latency with ack k cycles after bus_req rises (k>=1): stall high for k+1 cycles, low in the DONE cycle.
- Back-to-back accesses: the next request is seen in the IDLE cycle after DONE. No request is issued twice.
- bus_ack outside BUSY: ignored.

Optional Feature:
- Macro DMEM_WBUF_EN: one-entry posted write buffer.
- With DMEM_WBUF_EN:
  - A store seen in IDLE with the buffer empty is captured into the buffer that cycle. stall=0, and the FSM goes directly to BUSY to drain it. The pipeline is not held for stores.
  - Any request arriving while the buffer is still draining (BUSY on a buffered store) stalls until the drain reaches DONE, then is handled normally. A load therefore never bypasses a pending store.
  - Timeout on a buffered store pulses err; the store is dropped.
- Without DMEM_WBUF_EN: stores stall exactly like loads, per Behaviour.

Test Plan:
- Load: req_addr=0x0000_1006, bus_ack 3 cycles after bus_req, bus_rdata=0xA1B2C3D4 -> bus_addr=0x0000_1004, bus_be=1111, stall high 4 cycles, rdata=0xA1B2C3D4 in DONE, err=0.
- Store sb: req_amp=0100, req_wdata=0x00EE0000, ack after 1 cycle -> bus_we=1, bus_be=0100, stall 2 cycles. With DMEM_WBUF_EN: stall 0 cycles, bus_req still issued.
- Timeout: TIMEOUT=16, load, bus_ack never -> bus_req drops after 16 BUSY cycles, err pulses once, rdata=0, pipeline released.
- Store with req_amp=0000 -> no bus_req, stall 1 cycle, DONE, IDLE.
- Reset: assert reset=0 in the 2nd BUSY cycle -> bus_req=0 immediately; after release, a stray bus_ack is ignored and the next load completes normally.
- DMEM_WBUF_EN ordering: store to 0x20 (ack after 4 cycles) followed by a load from 0x20 -> the load's bus_req rises only after the store's ack; stall is asserted on the load until then.
